srpt_fetch_sched: RTL and testbench

- Sits between the SRPT fetch queue output FIFO and the host DMA read engine.
- Each fetch-queue entry is one cache-block fetch. The block pops it, allocates a DMA tag, and issues a read request.
- On each DMA completion, in any order, it emits a DBUFF_UPDATE queue entry back toward the send-side SRPT queue.
- Caps outstanding reads at MAX_OUTSTANDING.

---
 rtl/srpt_fetch_sched_pkg.sv | 46 ++++
 rtl/srpt_fetch_sched_if.sv | 35 +++
 rtl/srpt_tag_alloc.sv | 48 ++++
 rtl/srpt_fetch_sched.sv | 130 +++++++++++++
 tb/tb_srpt_fetch_sched.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srpt_fetch_sched_pkg.sv
// Shared SRPT definitions for the fetch scheduler: queue-entry priority
// codes, queue-entry field layout, cache-block size and DMA request layout.
// Ports: none (package).
package srpt_fetch_sched_pkg;

  // Queue entry priority codes
  typedef enum logic [2:0] {
    SRPT_INVALIDATE   = 3'b000,
    SRPT_DBUFF_UPDATE = 3'b001,
    SRPT_GRANT_UPDATE = 3'b010,
    SRPT_EMPTY        = 3'b011,
    SRPT_BLOCKED      = 3'b100,
    SRPT_ACTIVE       = 3'b101
  } srpt_prio_e;

  localparam int QUEUE_ENTRY_SIZE     = 99;
  localparam int QUEUE_ENTRY_RPC_ID   = 0;   // 15:0
  localparam int QUEUE_ENTRY_DBUFF_ID = 16;  // 24:16
  localparam int QUEUE_ENTRY_REMAIN   = 26;  // 45:26
  localparam int QUEUE_ENTRY_DBUFFED  = 46;  // 65:46
  localparam int QUEUE_ENTRY_GRANTED  = 66;  // 85:66
  localparam int QUEUE_ENTRY_PRIORITY = 86;  // 88:86

  localparam int CACHE_BLOCK_SIZE  = 64;
  localparam int HOMA_PAYLOAD_SIZE = 1386;

  // DMA request: {len, offset, dbuff_id, rpc_id, tag}, tag at the LSBs
  localparam int DMA_LEN_W    = 7;
  localparam int DMA_OFF_W    = 20;
  localparam int DMA_DBUFF_W  = 9;
  localparam int DMA_RPC_W    = 16;
  localparam int DMA_FIELDS_W = DMA_LEN_W + DMA_OFF_W + DMA_DBUFF_W + DMA_RPC_W;

  // Packed view of a queue entry; first member is the MSB end.
  typedef struct packed {
    logic [9:0]  rsvd_hi;
    logic [2:0]  prio;
    logic [19:0] granted;
    logic [19:0] dbuffered;
    logic [19:0] remaining;
    logic        rsvd_lo;
    logic [8:0]  dbuff_id;
    logic [15:0] rpc_id;
  } queue_entry_t;

endpackage

// File: rtl/srpt_fetch_sched_if.sv
// FIFO-side handshake bundle of the SRPT fetch scheduler.
//   slave  : scheduler view (pops fetch/completion FIFOs, pushes request/notification FIFOs)
//   master : environment view (FIFOs around the scheduler)
interface srpt_fetch_sched_if
  import srpt_fetch_sched_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic                                fetch_in_empty_i;
  logic                                fetch_in_read_en_o;
  logic [QUEUE_ENTRY_SIZE-1:0]         fetch_in_data_i;
  logic                                dma_req_full_i;
  logic                                dma_req_write_en_o;
  logic [TAG_W+DMA_FIELDS_W-1:0]       dma_req_data_o;
  logic                                dma_cmpl_empty_i;
  logic                                dma_cmpl_read_en_o;
  logic [TAG_W-1:0]                    dma_cmpl_data_i;
  logic                                dbuff_notif_full_i;
  logic                                dbuff_notif_write_en_o;
  logic [QUEUE_ENTRY_SIZE-1:0]         dbuff_notif_data_o;

  modport slave (
    input  fetch_in_empty_i, fetch_in_data_i, dma_req_full_i,
           dma_cmpl_empty_i, dma_cmpl_data_i, dbuff_notif_full_i,
    output fetch_in_read_en_o, dma_req_write_en_o, dma_req_data_o,
           dma_cmpl_read_en_o, dbuff_notif_write_en_o, dbuff_notif_data_o
  );

  modport master (
    output fetch_in_empty_i, fetch_in_data_i, dma_req_full_i,
           dma_cmpl_empty_i, dma_cmpl_data_i, dbuff_notif_full_i,
    input  fetch_in_read_en_o, dma_req_write_en_o, dma_req_data_o,
           dma_cmpl_read_en_o, dbuff_notif_write_en_o, dbuff_notif_data_o
  );
endinterface

// File: rtl/srpt_tag_alloc.sv
// DMA tag allocator: in-use bitmap with a lowest-index free-tag encoder.
// The encoder looks only at the registered bitmap, so a tag freed this
// cycle becomes allocatable next cycle.
// Ports: ap_clk/ap_rst_n (async active-low), alloc_i takes alloc_tag_o,
// free_i/free_tag_i releases a tag, any_free_o, in_use_o bitmap, count_o.
module srpt_tag_alloc #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       alloc_i,
  input  logic                       free_i,
  input  logic [TAG_W-1:0]           free_tag_i,
  output logic [TAG_W-1:0]           alloc_tag_o,
  output logic                       any_free_o,
  output logic [MAX_OUTSTANDING-1:0] in_use_o,
  output logic [TAG_W:0]             count_o
);
  localparam int CNT_W = TAG_W + 1;

  logic [MAX_OUTSTANDING-1:0] in_use_q;
  logic [MAX_OUTSTANDING-1:0] alloc_mask;
  logic [MAX_OUTSTANDING-1:0] free_mask;

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    alloc_tag_o = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!in_use_q[i]) alloc_tag_o = TAG_W'(i);
    end
  end

  assign any_free_o = ~&in_use_q;
  assign in_use_o   = in_use_q;
  assign alloc_mask = alloc_i ? (MAX_OUTSTANDING'(1) << alloc_tag_o) : '0;
  assign free_mask  = free_i  ? (MAX_OUTSTANDING'(1) << free_tag_i)  : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      in_use_q <= '0;
      count_o  <= '0;
    end else begin
      in_use_q <= (in_use_q | alloc_mask) & ~free_mask;
      count_o  <= count_o + CNT_W'(alloc_i) - CNT_W'(free_i);
    end
  end
endmodule

// File: rtl/srpt_fetch_sched.sv
// SRPT fetch scheduler: pops cache-block fetches from the fetch queue,
// allocates a DMA tag and issues a host read; on each (out-of-order) DMA
// completion emits a DBUFF_UPDATE queue entry toward the send-side queue.
// Ports: ap_clk, ap_rst_n (async active-low), bus (FIFO handshakes, slave
// modport), outstanding_o (tags in use), err_o (sticky: completion for a
// free tag).
// Optional: define SRPT_FETCH_STATS_EN to add stat_issued_o,
// stat_completed_o and stat_tag_stall_o wrapping 32-bit counters.
module srpt_fetch_sched
  import srpt_fetch_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  srpt_fetch_sched_if.slave   bus,
  output logic [TAG_W:0]      outstanding_o,
  output logic                err_o
`ifdef SRPT_FETCH_STATS_EN
  ,
  output logic [31:0]         stat_issued_o,
  output logic [31:0]         stat_completed_o,
  output logic [31:0]         stat_tag_stall_o
`endif
);

  function automatic logic [DMA_LEN_W-1:0] sat_len(input logic [19:0] remaining);
    return (remaining > 20'(CACHE_BLOCK_SIZE)) ? DMA_LEN_W'(CACHE_BLOCK_SIZE)
                                                : remaining[DMA_LEN_W-1:0];
  endfunction

  queue_entry_t               fetch_entry;
  queue_entry_t               notif_entry_p0;
  logic                       unused_fields;
  logic                       tag_free_any;
  logic [TAG_W-1:0]           alloc_tag;
  logic [MAX_OUTSTANDING-1:0] tag_in_use;
  logic                       issue_vld_p0;
  logic [DMA_LEN_W-1:0]       issue_len_p0;
  logic                       cmpl_hit_p0;
  logic                       cmpl_miss_p0;

  logic [15:0] tbl_rpc   [MAX_OUTSTANDING];
  logic [8:0]  tbl_dbuff [MAX_OUTSTANDING];
  logic [19:0] tbl_end   [MAX_OUTSTANDING];

  assign fetch_entry   = queue_entry_t'(bus.fetch_in_data_i);
  assign unused_fields = ^{fetch_entry.rsvd_hi, fetch_entry.granted, fetch_entry.rsvd_lo};

  // Gated by reset so no entry is popped (and lost) while held in reset.
  assign bus.fetch_in_read_en_o = ap_rst_n && !bus.fetch_in_empty_i &&
                                  !bus.dma_req_full_i && tag_free_any;
  assign bus.dma_cmpl_read_en_o = ap_rst_n && !bus.dma_cmpl_empty_i &&
                                  !bus.dbuff_notif_full_i;

  // Non-ACTIVE or zero-length entries are popped and dropped.
  assign issue_vld_p0 = bus.fetch_in_read_en_o && (fetch_entry.prio == SRPT_ACTIVE) &&
                        (fetch_entry.remaining != '0);
  assign issue_len_p0 = sat_len(fetch_entry.remaining);
  assign cmpl_hit_p0  = bus.dma_cmpl_read_en_o &&  tag_in_use[bus.dma_cmpl_data_i];
  assign cmpl_miss_p0 = bus.dma_cmpl_read_en_o && !tag_in_use[bus.dma_cmpl_data_i];

  always_comb begin
    notif_entry_p0           = '0;
    notif_entry_p0.prio      = SRPT_DBUFF_UPDATE;
    notif_entry_p0.rpc_id    = tbl_rpc[bus.dma_cmpl_data_i];
    notif_entry_p0.dbuff_id  = tbl_dbuff[bus.dma_cmpl_data_i];
    notif_entry_p0.dbuffered = tbl_end[bus.dma_cmpl_data_i];
  end

  srpt_tag_alloc #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TAG_W           (TAG_W)
  ) u_tag_alloc (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .alloc_i     (issue_vld_p0),
    .free_i      (cmpl_hit_p0),
    .free_tag_i  (bus.dma_cmpl_data_i),
    .alloc_tag_o (alloc_tag),
    .any_free_o  (tag_free_any),
    .in_use_o    (tag_in_use),
    .count_o     (outstanding_o)
  );

  // ---- stage p0 -> p1: register request / notification, update tag table
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bus.dma_req_write_en_o     <= 1'b0;
      bus.dma_req_data_o         <= '0;
      bus.dbuff_notif_write_en_o <= 1'b0;
      bus.dbuff_notif_data_o     <= '0;
      err_o                      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tbl_rpc[i]   <= '0;
        tbl_dbuff[i] <= '0;
        tbl_end[i]   <= '0;
      end
    end else begin
      bus.dma_req_write_en_o     <= issue_vld_p0;
      bus.dbuff_notif_write_en_o <= cmpl_hit_p0;
      if (issue_vld_p0) begin
        bus.dma_req_data_o   <= {issue_len_p0, fetch_entry.dbuffered, fetch_entry.dbuff_id,
                                 fetch_entry.rpc_id, alloc_tag};
        tbl_rpc[alloc_tag]   <= fetch_entry.rpc_id;
        tbl_dbuff[alloc_tag] <= fetch_entry.dbuff_id;
        tbl_end[alloc_tag]   <= fetch_entry.dbuffered + 20'(issue_len_p0);
      end
      if (cmpl_hit_p0)  bus.dbuff_notif_data_o <= notif_entry_p0;
      if (cmpl_miss_p0) err_o <= 1'b1;
    end
  end

`ifdef SRPT_FETCH_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_issued_o    <= '0;
      stat_completed_o <= '0;
      stat_tag_stall_o <= '0;
    end else begin
      if (issue_vld_p0) stat_issued_o    <= stat_issued_o + 32'd1;
      if (cmpl_hit_p0)  stat_completed_o <= stat_completed_o + 32'd1;
      if (!bus.fetch_in_empty_i && !bus.dma_req_full_i && !tag_free_any)
        stat_tag_stall_o <= stat_tag_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_srpt_fetch_sched.sv
module tb_srpt_fetch_sched;
  localparam int MAX   = 16;
  localparam int TAG_W = 4;
  localparam int RW    = TAG_W + 52;

  localparam logic [2:0] P_INVAL  = 3'd0;
  localparam logic [2:0] P_UPDATE = 3'd1;
  localparam logic [2:0] P_EMPTY  = 3'd3;
  localparam logic [2:0] P_ACTIVE = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [TAG_W:0] outstanding;
  logic err;

  srpt_fetch_sched_if #(.TAG_W(TAG_W)) bus ();

`ifdef SRPT_FETCH_STATS_EN
  logic [31:0] unused_stat_issued, unused_stat_completed, unused_stat_stall;
`endif

  srpt_fetch_sched #(.MAX_OUTSTANDING(MAX), .TAG_W(TAG_W)) dut (
    .ap_clk        (clk),
    .ap_rst_n      (rst_n),
    .bus           (bus),
    .outstanding_o (outstanding),
    .err_o         (err)
`ifdef SRPT_FETCH_STATS_EN
    ,
    .stat_issued_o    (unused_stat_issued),
    .stat_completed_o (unused_stat_completed),
    .stat_tag_stall_o (unused_stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Environment FIFOs and a transaction-level model of the scheduler.
  logic [98:0]    fq[$];
  logic [TAG_W-1:0] cq[$];
  bit             used[MAX];
  logic [15:0]    m_rpc[MAX];
  logic [8:0]     m_dbuff[MAX];
  logic [19:0]    m_end[MAX];
  bit             m_req_vld, m_notif_vld, m_err;
  logic [RW-1:0]  m_req;
  logic [98:0]    m_notif;

  logic [RW-1:0]  req_log[$];
  logic [98:0]    notif_log[$];
  int             notif_cyc[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;

  function automatic logic [98:0] mk_entry(input logic [2:0] prio, input logic [15:0] rpc,
                                           input logic [8:0] dbuff, input logic [19:0] rem,
                                           input logic [19:0] dbuffered, input logic [19:0] granted);
    logic [98:0] e;
    e = '0;
    e[15:0]  = rpc;
    e[24:16] = dbuff;
    e[45:26] = rem;
    e[65:46] = dbuffered;
    e[85:66] = granted;
    e[88:86] = prio;
    return e;
  endfunction

  function automatic int n_used();
    int n = 0;
    for (int i = 0; i < MAX; i++) if (used[i]) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.fetch_in_empty_i = (fq.size() == 0);
    bus.fetch_in_data_i  = (fq.size() != 0) ? fq[0] : '0;
    bus.dma_cmpl_empty_i = (cq.size() == 0);
    bus.dma_cmpl_data_i  = (cq.size() != 0) ? cq[0] : '0;
  endtask

  task automatic model_reset();
    fq.delete();
    cq.delete();
    for (int i = 0; i < MAX; i++) used[i] = 1'b0;
    m_req_vld = 1'b0;
    m_notif_vld = 1'b0;
    m_err = 1'b0;
    m_req = '0;
    m_notif = '0;
    drive();
  endtask

  // One clock: compare at the falling edge, predict the rising edge, update after it.
  task automatic step();
    bit e_frd, e_crd, do_alloc, do_free, miss;
    int at, ft, len, rem;
    logic [98:0] e;
    logic [RW-1:0] nreq;
    logic [98:0] nnot;
    @(negedge clk);
    cyc++;
    e_frd = (fq.size() != 0) && !bus.dma_req_full_i && (n_used() < MAX);
    e_crd = (cq.size() != 0) && !bus.dbuff_notif_full_i;
    check("fetch_rd", 128'(bus.fetch_in_read_en_o), 128'(e_frd));
    check("cmpl_rd", 128'(bus.dma_cmpl_read_en_o), 128'(e_crd));
    check("req_we", 128'(bus.dma_req_write_en_o), 128'(m_req_vld));
    if (m_req_vld) check("req_data", 128'(bus.dma_req_data_o), 128'(m_req));
    check("notif_we", 128'(bus.dbuff_notif_write_en_o), 128'(m_notif_vld));
    if (m_notif_vld) check("notif_data", 128'(bus.dbuff_notif_data_o), 128'(m_notif));
    check("outstanding", 128'(outstanding), 128'(n_used()));
    check("err", 128'(err), 128'(m_err));
    if (bus.dma_req_write_en_o) req_log.push_back(bus.dma_req_data_o);
    if (bus.dbuff_notif_write_en_o) begin
      notif_log.push_back(bus.dbuff_notif_data_o);
      notif_cyc.push_back(cyc);
    end
    do_alloc = 0; do_free = 0; miss = 0; at = 0; ft = 0; len = 0;
    nreq = '0; nnot = '0; e = '0;
    if (e_frd) begin
      e = fq[0];
      rem = int'(e[45:26]);
      if (e[88:86] == P_ACTIVE && rem != 0) begin
        do_alloc = 1;
        at = -1;
        for (int i = 0; i < MAX; i++) if (!used[i] && at < 0) at = i;
        len = (rem > 64) ? 64 : rem;
        nreq = {7'(len), e[65:46], e[24:16], e[15:0], TAG_W'(at)};
      end
    end
    if (e_crd) begin
      ft = int'(cq[0]);
      if (used[ft]) begin
        do_free = 1;
        nnot = mk_entry(P_UPDATE, m_rpc[ft], m_dbuff[ft], 20'd0, m_end[ft], 20'd0);
      end else begin
        miss = 1;
      end
    end
    @(posedge clk);
    #1;
    if (e_frd) void'(fq.pop_front());
    if (e_crd) void'(cq.pop_front());
    if (do_free) used[ft] = 1'b0;
    if (do_alloc) begin
      used[at]    = 1'b1;
      m_rpc[at]   = e[15:0];
      m_dbuff[at] = e[24:16];
      m_end[at]   = e[65:46] + 20'(len);
      m_req       = nreq;
    end
    m_req_vld = do_alloc;
    m_notif_vld = do_free;
    if (do_free) m_notif = nnot;
    if (miss) m_err = 1'b1;
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n0;
    bus.dma_req_full_i = 1'b0;
    bus.dbuff_notif_full_i = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_req_we", 128'(bus.dma_req_write_en_o), 128'(0));
    check("rst_req_data", 128'(bus.dma_req_data_o), 128'(0));
    check("rst_notif_we", 128'(bus.dbuff_notif_write_en_o), 128'(0));
    check("rst_notif_data", 128'(bus.dbuff_notif_data_o), 128'(0));
    check("rst_outstanding", 128'(outstanding), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First ACTIVE entry: tag 0, offset 0, len 64
    fq.push_back(mk_entry(P_ACTIVE, 16'd1, 9'd1, 20'd1000, 20'd0, 20'd777));
    drive();
    steps(2);
    check("first_req_count", 128'(req_log.size()), 128'(1));
    check("first_req", 128'(req_log[0]), 128'({7'd64, 20'd0, 9'd1, 16'd1, 4'd0}));
    check("first_outstanding", 128'(outstanding), 128'(1));

    // Short tail: len 40 from offset 960; its completion reports 1000
    fq.push_back(mk_entry(P_ACTIVE, 16'd2, 9'd2, 20'd40, 20'd960, 20'd5));
    drive();
    steps(2);
    check("tail_req", 128'(req_log[1]), 128'({7'd40, 20'd960, 9'd2, 16'd2, 4'd1}));
    cq.push_back(4'd1);
    drive();
    steps(2);
    check("tail_notif", 128'(notif_log[0]),
          128'(mk_entry(P_UPDATE, 16'd2, 9'd2, 20'd0, 20'd1000, 20'd0)));
    check("tail_outstanding", 128'(outstanding), 128'(1));
    cq.push_back(4'd0);
    drive();
    steps(2);
    check("first_notif", 128'(notif_log[1]),
          128'(mk_entry(P_UPDATE, 16'd1, 9'd1, 20'd0, 20'd64, 20'd0)));
    check("drained_outstanding", 128'(outstanding), 128'(0));

    // 17 entries against 16 tags
    req_log.delete();
    for (int i = 0; i < 17; i++)
      fq.push_back(mk_entry(P_ACTIVE, 16'(100 + i), 9'(i), 20'd2000, 20'(64 * i), 20'd0));
    drive();
    steps(20);
    check("full_req_count", 128'(req_log.size()), 128'(16));
    check("full_fifo_held", 128'(fq.size()), 128'(1));
    check("full_outstanding", 128'(outstanding), 128'(16));
    for (int i = 0; i < 16; i++) check("full_tag_order", 128'(req_log[i][3:0]), 128'(i));
    cq.push_back(4'd5);
    drive();
    steps(4);
    check("refill_req_count", 128'(req_log.size()), 128'(17));
    check("refill_tag", 128'(req_log[16][3:0]), 128'(5));
    check("refill_rpc", 128'(req_log[16][19:4]), 128'(116));

    // Out-of-order completions 3,0,2,1 then the rest
    notif_log.delete();
    notif_cyc.delete();
    cq.push_back(4'd3); cq.push_back(4'd0); cq.push_back(4'd2); cq.push_back(4'd1);
    for (int i = 4; i < 16; i++) if (i != 5) cq.push_back(4'(i));
    cq.push_back(4'd5);
    drive();
    steps(20);
    check("ooo_rpc0", 128'(notif_log[0][15:0]), 128'(103));
    check("ooo_rpc1", 128'(notif_log[1][15:0]), 128'(100));
    check("ooo_rpc2", 128'(notif_log[2][15:0]), 128'(102));
    check("ooo_rpc3", 128'(notif_log[3][15:0]), 128'(101));
    check("ooo_dbuffered0", 128'(notif_log[0][65:46]), 128'(256));
    check("ooo_notif_count", 128'(notif_log.size()), 128'(16));
    check("ooo_outstanding", 128'(outstanding), 128'(0));

    // Completion of a free tag, and entries that must be dropped
    n0 = notif_log.size();
    cq.push_back(4'd7);
    drive();
    steps(3);
    check("stray_err", 128'(err), 128'(1));
    check("stray_no_notif", 128'(notif_log.size()), 128'(n0));
    req_log.delete();
    fq.push_back(mk_entry(P_EMPTY, 16'd50, 9'd3, 20'd500, 20'd0, 20'd0));
    fq.push_back(mk_entry(P_INVAL, 16'd51, 9'd4, 20'd500, 20'd0, 20'd0));
    fq.push_back(mk_entry(P_ACTIVE, 16'd52, 9'd5, 20'd0, 20'd0, 20'd0));
    drive();
    steps(5);
    check("drop_no_req", 128'(req_log.size()), 128'(0));
    check("drop_fifo_empty", 128'(fq.size()), 128'(0));
    check("err_sticky", 128'(err), 128'(1));

    // Notification back-pressure
    fq.push_back(mk_entry(P_ACTIVE, 16'd200, 9'd10, 20'd64, 20'd0, 20'd0));
    fq.push_back(mk_entry(P_ACTIVE, 16'd201, 9'd11, 20'd64, 20'd64, 20'd0));
    drive();
    steps(3);
    bus.dbuff_notif_full_i = 1'b1;
    cq.push_back(4'd0);
    cq.push_back(4'd1);
    drive();
    steps(3);
    check("bp_cmpl_rd", 128'(bus.dma_cmpl_read_en_o), 128'(0));
    n0 = notif_log.size();
    bus.dbuff_notif_full_i = 1'b0;
    steps(4);
    check("bp_notif_count", 128'(notif_log.size()), 128'(n0 + 2));
    check("bp_back_to_back", 128'(notif_cyc[n0 + 1] - notif_cyc[n0]), 128'(1));
    check("bp_rpc_a", 128'(notif_log[n0][15:0]), 128'(200));
    check("bp_rpc_b", 128'(notif_log[n0 + 1][15:0]), 128'(201));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      fq.push_back(mk_entry(P_ACTIVE, 16'(300 + i), 9'd1, 20'd100, 20'd0, 20'd0));
    drive();
    steps(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req_we", 128'(bus.dma_req_write_en_o), 128'(0));
    check("arst_req_data", 128'(bus.dma_req_data_o), 128'(0));
    check("arst_notif_we", 128'(bus.dbuff_notif_write_en_o), 128'(0));
    check("arst_notif_data", 128'(bus.dbuff_notif_data_o), 128'(0));
    check("arst_outstanding", 128'(outstanding), 128'(0));
    check("arst_err", 128'(err), 128'(0));
    check("arst_fetch_rd", 128'(bus.fetch_in_read_en_o), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = notif_log.size();
    cq.push_back(4'd0);
    drive();
    steps(3);
    check("late_cmpl_err", 128'(err), 128'(1));
    check("late_cmpl_no_notif", 128'(notif_log.size()), 128'(n0));
    req_log.delete();
    fq.push_back(mk_entry(P_ACTIVE, 16'd400, 9'd7, 20'd10, 20'd30, 20'd0));
    drive();
    steps(3);
    check("post_rst_req", 128'(req_log[0]), 128'({7'd10, 20'd30, 9'd7, 16'd400, 4'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
